// File: rtl/gf2_poly_div_if.sv
// Handshake and data bundle for the bit-serial GF(2)[x] divider.
interface gf2_poly_div_if #(
  parameter int N = 5,
  parameter int M = 3
);
  logic         start;
  logic [N-1:0] a;
  logic [M-1:0] b;
  logic         busy;
  logic         done;
  logic         err;
  logic [N-1:0] q;
  logic [M-2:0] r;

  modport master (output start, a, b, input busy, done, err, q, r);
  modport slave  (input start, a, b, output busy, done, err, q, r);
endinterface

// File: rtl/gf2_poly_div.sv
// Bit-serial GF(2)[x] divider: normalises the divisor so its top bit is set,
// long-divides one quotient bit per cycle, then shifts the remainder back.
module gf2_poly_div #(
  parameter int N = 5,
  parameter int M = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  gf2_poly_div_if.slave bus
);
  localparam int CW = $clog2(N + M) + 1;
  localparam int SW = $clog2(M) + 1;

  typedef enum logic [2:0] {S_IDLE, S_NORM, S_DIV, S_DENORM, S_DONE} state_t;

  state_t        r_state;
  logic [N-1:0]  r_a;
  logic [M-1:0]  r_b;
  logic [M-2:0]  r_rem;
  logic [N-1:0]  r_quo;
  logic [SW-1:0] r_s;
  logic [CW-1:0] r_cnt;
  logic          r_err_pend;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [N-1:0]  r_q;
  logic [M-2:0]  r_r;

  logic [M-1:0]  w_t;
  logic [M-2:0]  w_sub;

  // Top bit of T always cancels against the normalised divisor's top bit.
  assign w_t   = {r_rem, r_a[N-1]};
  assign w_sub = w_t[M-2:0] ^ r_b[M-2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_s        <= '0;
      r_cnt      <= '0;
      r_err_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_q        <= '0;
      r_r        <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_rem <= '0;
            r_quo <= '0;
            r_s   <= '0;
            r_a   <= bus.a;
            r_b   <= bus.b;
            if (bus.b == '0) begin
              r_err_pend <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_err_pend <= 1'b0;
              r_busy     <= 1'b1;
              r_state    <= S_NORM;
            end
          end
        end
        S_NORM: begin
          if (r_b[M-1]) begin
            r_cnt   <= CW'(N) + CW'(r_s);
            r_state <= S_DIV;
          end else begin
            r_b <= r_b << 1;
            r_s <= r_s + SW'(1);
          end
        end
        S_DIV: begin
          r_rem <= w_t[M-1] ? w_sub : w_t[M-2:0];
          r_quo <= {r_quo[N-2:0], w_t[M-1]};
          r_a   <= {r_a[N-2:0], 1'b0};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            if (r_s != '0) begin
              r_state <= S_DENORM;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end
          end
        end
        S_DENORM: begin
          r_rem <= r_rem >> 1;
          r_s   <= r_s - SW'(1);
          if (r_s == SW'(1)) begin
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_q     <= r_quo;
          r_r     <= r_rem;
          r_err   <= r_err_pend;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err  = r_err;
  assign bus.q    = r_q;
  assign bus.r    = r_r;
endmodule

// File: tb/tb_gf2_poly_div.sv
// Directed and round-trip checks for gf2_poly_div with N=5, M=3.
module tb_gf2_poly_div;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  gf2_poly_div_if #(.N(5), .M(3)) bus ();

  gf2_poly_div #(.N(5), .M(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] a;
    logic [2:0] b;
    logic [4:0] q;
    logic [1:0] r;
    logic       err;
    int         lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int clmul(input int x, input int y);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (y[i]) p = p ^ (x << i);
    return p;
  endfunction

  function automatic int deg3(input int v);
    for (int i = 2; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that raised done.
  task automatic run_op(input logic [4:0] ta, input logic [2:0] tb_v,
                        output logic [4:0] oq, output logic [1:0] orr,
                        output logic oe, output int lat);
    bus.a = ta;
    bus.b = tb_v;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_seen", int'(bus.done), 1);
    oq  = bus.q;
    orr = bus.r;
    oe  = bus.err;
    $display("op a=%b b=%b -> q=%b r=%b err=%b lat=%0d", ta, tb_v, oq, orr, oe, lat);
  endtask

  initial begin
    logic [4:0] q;
    logic [1:0] r;
    logic       e;
    int         lat;
    int         cnt;
    int         first_k;
    int         second_k;

    n_pass = 0;
    n_total = 0;
    vecs[0]  = '{5'b10101, 3'b111, 5'b00111, 2'b00, 1'b0, 7};
    vecs[1]  = '{5'b10101, 3'b011, 5'b01100, 2'b01, 1'b0, 10};
    vecs[2]  = '{5'b10101, 3'b001, 5'b10101, 2'b00, 1'b0, 13};
    vecs[3]  = '{5'b11111, 3'b000, 5'b00000, 2'b00, 1'b1, 1};
    vecs[4]  = '{5'b10101, 3'b111, 5'b00111, 2'b00, 1'b0, 7};
    vecs[5]  = '{5'b00000, 3'b111, 5'b00000, 2'b00, 1'b0, 7};
    vecs[6]  = '{5'b00000, 3'b001, 5'b00000, 2'b00, 1'b0, 13};
    vecs[7]  = '{5'b11111, 3'b110, 5'b00101, 2'b01, 1'b0, 7};
    vecs[8]  = '{5'b00011, 3'b010, 5'b00001, 2'b01, 1'b0, 10};
    vecs[9]  = '{5'b10000, 3'b100, 5'b00100, 2'b00, 1'b0, 7};
    vecs[10] = '{5'b01101, 3'b101, 5'b00011, 2'b10, 1'b0, 7};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err",  int'(bus.err), 0);
    check("rst_q",    int'(bus.q), 0);
    check("rst_r",    int'(bus.r), 0);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, q, r, e, lat);
      check("vec_q",   int'(q), int'(vecs[i].q));
      check("vec_r",   int'(r), int'(vecs[i].r));
      check("vec_err", int'(e), int'(vecs[i].err));
      check("vec_lat", lat, vecs[i].lat);
    end

    // Outputs persist after the done pulse.
    repeat (3) @(posedge clk);
    #1;
    check("hold_done", int'(bus.done), 0);
    check("hold_q",    int'(bus.q), 5'b00011);
    check("hold_r",    int'(bus.r), 2'b10);

    // Start ignored while busy.
    bus.a = 5'b10101;
    bus.b = 3'b001;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    repeat (4) begin @(posedge clk); #1; lat++; end
    check("busy_mid", int'(bus.busy), 1);
    bus.a = 5'b11111;
    bus.b = 3'b111;
    bus.start = 1'b1;
    @(posedge clk); #1;
    lat++;
    bus.start = 1'b0;
    while (!bus.done && lat < 100) begin @(posedge clk); #1; lat++; end
    $display("op busy-start q=%b r=%b lat=%0d", bus.q, bus.r, lat);
    check("ign_lat", lat, 13);
    check("ign_q", int'(bus.q), 5'b10101);
    check("ign_r", int'(bus.r), 0);
    cnt = 0;
    repeat (20) begin @(posedge clk); #1; if (bus.done) cnt++; end
    check("ign_no_extra_done", cnt, 0);

    // Reset mid-DIV aborts without a done pulse.
    bus.a = 5'b10101;
    bus.b = 3'b001;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    $display("op reset-mid-div busy=%b q=%b", bus.busy, bus.q);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_done", int'(bus.done), 0);
    check("arst_err",  int'(bus.err), 0);
    check("arst_q",    int'(bus.q), 0);
    check("arst_r",    int'(bus.r), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin @(posedge clk); #1; if (bus.done || bus.busy) cnt++; end
    check("arst_quiet", cnt, 0);

    // Held start: back-to-back with one idle cycle.
    bus.a = 5'b10101;
    bus.b = 3'b111;
    bus.start = 1'b1;
    first_k = -1;
    second_k = -1;
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        if (first_k < 0) first_k = k;
        else if (second_k < 0) second_k = k;
      end
    end
    bus.start = 1'b0;
    $display("op held-start done at %0d and %0d", first_k, second_k);
    check("held_first", first_k, 7);
    check("held_second", second_k, 15);
    repeat (30) @(posedge clk);
    #1;

    // Round trip: (x*y)/y == x.
    for (int x = 0; x < 8; x++) begin
      for (int y = 1; y < 8; y++) begin
        run_op(5'(clmul(x, y)), 3'(y), q, r, e, lat);
        check("rt_q", int'(q), x);
        check("rt_r", int'(r), 0);
      end
    end

    // Random identity a == q*b ^ r with deg r < deg b.
    for (int i = 0; i < 20; i++) begin
      int ra;
      int rb;
      ra = int'($urandom_range(0, 31));
      rb = int'($urandom_range(1, 7));
      run_op(5'(ra), 3'(rb), q, r, e, lat);
      check("rnd_identity", clmul(int'(q), rb) ^ int'(r), ra);
      check("rnd_deg", int'(r) >> deg3(rb), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
